// File: rtl/uart_multi_monitor.sv
// uart_multi_monitor: multi-channel UART loopback and line monitor.
// Each channel synchronises its rx line, drives a registered loopback tx
// (idle high when loopback is off), exposes registered rx/tx taps, counts
// good 8N1 frames and framing errors, and flags recent line activity.
// Optional build macro: UART_BREAK_DETECT_EN adds per-channel line-break
// detection; when it is undefined break_det is tied low.
// state_dbg exposes each channel's frame FSM state (2 bits per channel,
// ch i at [2*i +: 2]; 0=IDLE 1=START 2=DATA 3=STOP).
module uart_multi_monitor #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16,
  parameter int ACT_CYCLES   = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       rx,
  input  logic [CHANNELS-1:0]       loopback_enable,
  input  logic                      cnt_clear,
  output logic [CHANNELS-1:0]       tx,
  output logic [CHANNELS-1:0]       rx_monitor,
  output logic [CHANNELS-1:0]       tx_monitor,
  output logic [CHANNELS*CNT_W-1:0] frame_cnt,
  output logic [CHANNELS*CNT_W-1:0] ferr_cnt,
  output logic [CHANNELS-1:0]       active,
  output logic [CHANNELS-1:0]       break_det,
  output logic [2*CHANNELS-1:0]     state_dbg
);

  localparam int BT_W  = $clog2(CLKS_PER_BIT);
  localparam int ACT_W = $clog2(ACT_CYCLES + 1);

  localparam logic [BT_W-1:0]  BT_HALF  = BT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BT_W-1:0]  BT_FULL  = BT_W'(CLKS_PER_BIT - 1);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   tx_q;
    logic                   rx_mon_q;
    logic                   tx_mon_q;
    state_t                 state_q;
    state_t                 state_d;
    logic [BT_W-1:0]        bt_q;
    logic [BT_W-1:0]        bt_d;
    logic [2:0]             bi_q;
    logic [2:0]             bi_d;
    logic                   frame_inc;
    logic                   ferr_inc;
    logic [CNT_W-1:0]       frame_q;
    logic [CNT_W-1:0]       ferr_q;
    logic [ACT_W-1:0]       act_q;
    logic                   active_q;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser for the asynchronous rx line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx[g]};
    end

    // Loopback output, monitor taps and the previous rx_s used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rx_prev  <= 1'b1;
        tx_q     <= 1'b1;
        rx_mon_q <= 1'b1;
        tx_mon_q <= 1'b1;
      end else begin
        rx_prev  <= rx_s;
        tx_q     <= loopback_enable[g] ? rx_s : 1'b1;
        rx_mon_q <= rx_s;
        tx_mon_q <= tx_q;
      end
    end

    // Frame FSM state, bit timer and bit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        bt_q    <= '0;
        bi_q    <= '0;
      end else begin
        state_q <= state_d;
        bt_q    <= bt_d;
        bi_q    <= bi_d;
      end
    end

    // Frame FSM next state: mid-bit sampling of start, 8 data bits and stop bit.
    always_comb begin
      state_d   = state_q;
      bt_d      = bt_q + BT_W'(1);
      bi_d      = bi_q;
      frame_inc = 1'b0;
      ferr_inc  = 1'b0;
      case (state_q)
        S_IDLE: begin
          bt_d = '0;
          if (rx_prev && !rx_s) state_d = S_START;
        end
        S_START: begin
          if (bt_q == BT_HALF) begin
            bt_d    = '0;
            bi_d    = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bt_q == BT_FULL) begin
            bt_d = '0;
            bi_d = bi_q + 3'd1;
            if (bi_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (bt_q == BT_FULL) begin
            bt_d      = '0;
            state_d   = S_IDLE;
            frame_inc = rx_s;
            ferr_inc  = !rx_s;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Saturating frame/error counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frame_q <= '0;
        ferr_q  <= '0;
      end else if (cnt_clear) begin
        frame_q <= '0;
        ferr_q  <= '0;
      end else begin
        if (frame_inc && frame_q != CNT_MAX) frame_q <= frame_q + CNT_W'(1);
        if (ferr_inc && ferr_q != CNT_MAX)   ferr_q  <= ferr_q + CNT_W'(1);
      end
    end

    // Activity timer: reload on any rx_s edge, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act_q    <= '0;
        active_q <= 1'b0;
      end else begin
        if (rx_s != rx_prev)   act_q <= ACT_LOAD;
        else if (act_q != '0)  act_q <= act_q - ACT_W'(1);
        active_q <= (act_q != '0);
      end
    end

`ifdef UART_BREAK_DETECT_EN
    localparam int BRK_LIM = 10 * CLKS_PER_BIT;
    localparam int BRK_W   = $clog2(BRK_LIM + 1);
    localparam logic [BRK_W-1:0] BRK_MAX = BRK_W'(BRK_LIM);

    logic [BRK_W-1:0] low_q;
    logic [BRK_W-1:0] low_d;
    logic             brk_q;

    // Next low-run length: zero while high, saturating count while low.
    always_comb begin
      low_d = '0;
      if (!rx_s) low_d = (low_q == BRK_MAX) ? BRK_MAX : low_q + BRK_W'(1);
    end

    // Break flag asserts once the line has been low for ten bit times.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        low_q <= '0;
        brk_q <= 1'b0;
      end else begin
        low_q <= low_d;
        brk_q <= (low_d == BRK_MAX);
      end
    end

    assign break_det[g] = brk_q;
`else
    assign break_det[g] = 1'b0;
`endif

    assign tx[g]                         = tx_q;
    assign rx_monitor[g]                 = rx_mon_q;
    assign tx_monitor[g]                 = tx_mon_q;
    assign frame_cnt[g*CNT_W +: CNT_W]   = frame_q;
    assign ferr_cnt[g*CNT_W +: CNT_W]    = ferr_q;
    assign active[g]                     = active_q;
    assign state_dbg[2*g +: 2]           = state_q;
  end

endmodule

// File: tb/tb_uart_multi_monitor.sv
// tb_uart_multi_monitor: directed bench for uart_multi_monitor with
// CHANNELS=4, SYNC_STAGES=2, CLKS_PER_BIT=16, CNT_W=4, ACT_CYCLES=64.
// A per-cycle loopback scoreboard models tx/rx_monitor/tx_monitor; frame
// counts come from a small saturating model updated as frames are sent.
module tb_uart_multi_monitor;
  localparam int CH  = 4;
  localparam int CPB = 16;
  localparam int CW  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0]    rx = '1;
  logic [CH-1:0]    en = '0;
  logic             cnt_clear = 1'b0;
  logic [CH-1:0]    tx, rx_monitor, tx_monitor, active, break_det;
  logic [CH*CW-1:0] frame_cnt, ferr_cnt;
  logic [2*CH-1:0]  state_dbg;

  uart_multi_monitor #(
    .CHANNELS(CH), .SYNC_STAGES(2), .CLKS_PER_BIT(CPB), .CNT_W(CW), .ACT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .loopback_enable(en), .cnt_clear(cnt_clear),
    .tx(tx), .rx_monitor(rx_monitor), .tx_monitor(tx_monitor),
    .frame_cnt(frame_cnt), .ferr_cnt(ferr_cnt), .active(active),
    .break_det(break_det), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [CH-1:0] exp_q[$];
  logic          lb_on = 1'b0;
  logic [CH-1:0] prev_tx_exp = '1;
  logic [CH-1:0] r_old, en_now, tx_exp;
  int            exp_frame[CH];
  int            exp_ferr[CH];

  // rx sampled at edge n reaches rx_monitor/tx at edge n+2 (tx gated by en at that edge)
  always @(posedge clk) begin
    if (lb_on) begin
      exp_q.push_back(rx);
      en_now = en;
      r_old  = exp_q.pop_front();
      tx_exp = (r_old & en_now) | ~en_now;
      #1;
      check("tx", 32'(tx), 32'(tx_exp));
      check("rx_monitor", 32'(rx_monitor), 32'(r_old));
      check("tx_monitor", 32'(tx_monitor), 32'(prev_tx_exp));
      prev_tx_exp = tx_exp;
    end
  end

  function automatic logic [CH*CW-1:0] pack_cnt(input bit errs);
    logic [CH*CW-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++)
      v[i*CW +: CW] = CW'(errs ? exp_ferr[i] : exp_frame[i]);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame"}, 32'(frame_cnt), 32'(pack_cnt(1'b0)));
    check({tag, "_ferr"},  32'(ferr_cnt),  32'(pack_cnt(1'b1)));
  endtask

  // 8N1 frame; optional cnt_clear pulse aligned to the stop-bit sample edge
  task automatic send_frame(input int ch, input logic [7:0] data, input logic stop, input bit clr);
    rx[ch] = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx[ch] = data[i];
      cyc(CPB);
    end
    rx[ch] = stop;
    if (clr) begin
      cyc(10);
      cnt_clear = 1'b1;
      cyc(1);
      cnt_clear = 1'b0;
      cyc(CPB - 11);
    end else begin
      cyc(CPB);
    end
    rx[ch] = 1'b1;
    cyc(CPB);
    if (clr) begin
      for (int i = 0; i < CH; i++) begin
        exp_frame[i] = 0;
        exp_ferr[i]  = 0;
      end
    end else if (stop) begin
      if (exp_frame[ch] < 15) exp_frame[ch]++;
    end else begin
      if (exp_ferr[ch] < 15) exp_ferr[ch]++;
    end
  endtask

  task automatic start_scoreboard();
    exp_q.delete();
    exp_q.push_back('1);
    exp_q.push_back('1);
    prev_tx_exp = '1;
    lb_on = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < CH; i++) begin
      exp_frame[i] = 0;
      exp_ferr[i]  = 0;
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // 1: reset in the middle of traffic
    en = '1;
    rx[0] = 1'b0;
    cyc(20);
    rx[0] = 1'b1;
    cyc(3);
    rx[1] = 1'b0;
    cyc(30);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'hF);
    check("rst_rx_monitor", 32'(rx_monitor), 32'hF);
    check("rst_tx_monitor", 32'(tx_monitor), 32'hF);
    check_counts("rst");
    check("rst_active", 32'(active), 32'h0);
    check("rst_break", 32'(break_det), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rx = '1;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    check_counts("post_rst");
    check("post_rst_state", 32'(state_dbg), 32'h0);
    start_scoreboard();

    // 2: good frame 0x55 on ch0 with loopback on ch0 only
    en = 4'b0001;
    send_frame(0, 8'h55, 1'b1, 1'b0);
    check_counts("f55");
    check("act_hold", 32'(active), 32'h1);
    cyc(30);
    check("act_late", 32'(active), 32'h1);
    cyc(10);
    check("act_expire", 32'(active), 32'h0);

    // 3: loopback off, short pulses on ch1, then a stop-bit-0 frame
    en = 4'b0000;
    for (int p = 0; p < 6; p++) begin
      rx[1] = 1'b0;
      cyc($urandom_range(1, 5));
      rx[1] = 1'b1;
      cyc(2);
      check("tx1_idle", 32'(tx[1]), 32'h1);
      cyc(12);
    end
    check_counts("pulses");
    send_frame(1, 8'hA3, 1'b0, 1'b0);
    check_counts("ferr1");

    // 4: 3-cycle glitch on ch2
    rx[2] = 1'b0;
    cyc(3);
    rx[2] = 1'b1;
    cyc(30);
    check_counts("glitch");
    check("glitch_state", 32'(state_dbg[5:4]), 32'h0);

    // 5: saturation on ch3, then clear coinciding with a stop sample
    en = 4'b1010;
    for (int f = 0; f < 17; f++)
      send_frame(3, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    check_counts("sat");
    check("sat_ch3", 32'(frame_cnt[15:12]), 32'hF);
    send_frame(3, 8'h0F, 1'b1, 1'b1);
    check_counts("clear");
    send_frame(3, 8'hC3, 1'b1, 1'b0);
    check_counts("after_clear");

    // 6: long low on ch0
    en = 4'b0001;
    rx[0] = 1'b0;
`ifdef UART_BREAK_DETECT_EN
    cyc(161);
    check("brk_before", 32'(break_det), 32'h0);
    cyc(1);
    check("brk_set", 32'(break_det), 32'h1);
    cyc(38);
    rx[0] = 1'b1;
    cyc(2);
    check("brk_hold", 32'(break_det), 32'h1);
    cyc(1);
    check("brk_release", 32'(break_det), 32'h0);
`else
    cyc(200);
    check("brk_off_low", 32'(break_det), 32'h0);
    rx[0] = 1'b1;
    cyc(3);
    check("brk_off_rel", 32'(break_det), 32'h0);
`endif
    cyc(20);
    if (exp_ferr[0] < 15) exp_ferr[0]++;
    check_counts("break_frame");

    lb_on = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
